// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes,
// FSM state encoding and the trap EPC helper.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int IM_LO        = 10;
  localparam int IM_HI        = 15;
  localparam int CAUSE_BD_BIT = 31;
  localparam int EXC_LO       = 2;
  localparam int EXC_HI       = 6;

  localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] DEF_PRID_VAL     = 32'h2018_1225;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // FSM state encoding matches SR.EXL so the two can be compared directly.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] trap_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] raw;
    raw = bd ? (pc - 32'd4) : pc;
    return {raw[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline <-> CP0 bundle. Every input is sampled on the rising clock edge;
// outputs marked combinational react within the same cycle.
interface cp0_exc_ctrl_if;
  import cp0_exc_ctrl_pkg::*;

  logic [31:0] PC_M;
  logic        Valid_M;
  logic [6:2]  ExcCode_M;
  logic        BD_M;
  logic [7:2]  HWInt;
  logic        WE;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        EretM;
  logic [31:0] DOut;
  logic [31:0] EPC_out;
  logic        Flush;
  logic        Redirect;
  logic [31:0] Target;
  logic        EXL;
  cp0_state_e  state_dbg;

  modport master (
    output PC_M, Valid_M, ExcCode_M, BD_M, HWInt, WE, A1, A2, DIn, EretM,
    input  DOut, EPC_out, Flush, Redirect, Target, EXL, state_dbg
  );

  modport slave (
    input  PC_M, Valid_M, ExcCode_M, BD_M, HWInt, WE, A1, A2, DIn, EretM,
    output DOut, EPC_out, Flush, Redirect, Target, EXL, state_dbg
  );
endinterface

// File: rtl/cp0_exc_ctrl_regfile.sv
// SR/Cause/EPC/PrID storage and the mfc0 read mux. A trap update takes
// precedence over a same-cycle mtc0; eret only clears EXL.
module cp0_exc_ctrl_regfile
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = DEF_PRID_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap_i,
  input  logic        trap_bd_i,
  input  logic [31:0] trap_epc_i,
  input  logic [4:0]  trap_code_i,
  input  logic        eret_i,
  input  logic [5:0]  hwint_i,
  input  logic        we_i,
  input  logic [4:0]  a1_i,
  input  logic [4:0]  a2_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o,
  output logic [31:0] epc_o,
  output logic [5:0]  im_o,
  output logic        ie_o,
  output logic        exl_o
);

  logic [5:0]  im_q;
  logic        ie_q;
  logic        exl_q;
  logic        bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q   <= '0;
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      ip_q <= hwint_i;
      if (trap_i) begin
        exl_q  <= 1'b1;
        bd_q   <= trap_bd_i;
        epc_q  <= trap_epc_i;
        code_q <= trap_code_i;
      end else begin
        if (we_i && a2_i == CP0_SR) begin
          im_q  <= din_i[IM_HI:IM_LO];
          ie_q  <= din_i[SR_IE_BIT];
          exl_q <= din_i[SR_EXL_BIT];
        end
        if (we_i && a2_i == CP0_EPC) begin
          epc_q <= din_i;
        end
        // Placed last so eret beats an mtc0 SR in the same cycle.
        if (eret_i) begin
          exl_q <= 1'b0;
        end
      end
    end
  end

  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_comb begin
    sr_word                   = '0;
    sr_word[IM_HI:IM_LO]      = im_q;
    sr_word[SR_EXL_BIT]       = exl_q;
    sr_word[SR_IE_BIT]        = ie_q;
    cause_word                = '0;
    cause_word[CAUSE_BD_BIT]  = bd_q;
    cause_word[IM_HI:IM_LO]   = ip_q;
    cause_word[EXC_HI:EXC_LO] = code_q;
    case (a1_i)
      CP0_SR:    dout_o = sr_word;
      CP0_CAUSE: dout_o = cause_word;
      CP0_EPC:   dout_o = epc_q;
      CP0_PRID:  dout_o = PRID_VAL;
      default:   dout_o = '0;
    endcase
  end

  assign epc_o = epc_q;
  assign im_o  = im_q;
  assign ie_o  = ie_q;
  assign exl_o = exl_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Trap/eret decision FSM for the M stage. Flush, Redirect and Target are
// combinational so fetch is redirected in the same cycle the trap is seen.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
  parameter logic [31:0] PRID_VAL     = DEF_PRID_VAL
) (
  input  logic           clk,
  input  logic           reset,
  cp0_exc_ctrl_if.slave  bus
);

  cp0_state_e  state_q;
  logic [5:0]  im;
  logic        ie;
  logic        exl;
  logic [31:0] epc_q;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        eret_take;
  logic [4:0]  trap_code;
  logic [31:0] epc_out;
  logic        sr_write;

  // Requests are masked in the handler and while reset is held.
  assign int_req   = (|(bus.HWInt & im)) & ie & bus.Valid_M
                     & (state_q == ST_RUN) & ~reset;
  assign exc_req   = (bus.ExcCode_M != 5'd0) & bus.Valid_M
                     & (state_q == ST_RUN) & ~reset;
  assign req       = int_req | exc_req;
  assign eret_take = bus.EretM & (state_q == ST_HANDLER) & ~reset;
  assign trap_code = int_req ? EXC_INT : bus.ExcCode_M;
  assign sr_write  = bus.WE && (bus.A2 == CP0_SR);

  // Bypass lets an eret directly after an mtc0 EPC return to the new value.
  assign epc_out = (bus.WE && bus.A2 == CP0_EPC) ? bus.DIn : epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (req)                           state_q <= ST_HANDLER;
          else if (sr_write && bus.DIn[SR_EXL_BIT])  state_q <= ST_HANDLER;
        end
        ST_HANDLER: begin
          if (eret_take)                     state_q <= ST_RUN;
          else if (sr_write && !bus.DIn[SR_EXL_BIT]) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  cp0_exc_ctrl_regfile #(
    .PRID_VAL (PRID_VAL)
  ) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .trap_i      (req),
    .trap_bd_i   (bus.BD_M),
    .trap_epc_i  (trap_epc(bus.PC_M, bus.BD_M)),
    .trap_code_i (trap_code),
    .eret_i      (eret_take),
    .hwint_i     (bus.HWInt),
    .we_i        (bus.WE),
    .a1_i        (bus.A1),
    .a2_i        (bus.A2),
    .din_i       (bus.DIn),
    .dout_o      (bus.DOut),
    .epc_o       (epc_q),
    .im_o        (im),
    .ie_o        (ie),
    .exl_o       (exl)
  );

  assign bus.EPC_out   = epc_out;
  assign bus.Flush     = req | eret_take;
  assign bus.Redirect  = req | eret_take;
  assign bus.Target    = req ? HANDLER_ADDR : (eret_take ? epc_out : 32'd0);
  assign bus.EXL       = exl;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: trap, delay slot, bubble deferral,
// masking, eret bypass, mtc0 collision, reads and mid-handler reset.
module tb_cp0_exc_ctrl;
  import cp0_exc_ctrl_pkg::*;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h2018_1225;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  cp0_exc_ctrl_if bus();

  cp0_exc_ctrl #(
    .HANDLER_ADDR (HANDLER),
    .PRID_VAL     (PRID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", obs, 32'hxxxx_xxxx);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.PC_M      = 32'd0;
    bus.Valid_M   = 1'b0;
    bus.ExcCode_M = 5'd0;
    bus.BD_M      = 1'b0;
    bus.WE        = 1'b0;
    bus.A2        = 5'd0;
    bus.DIn       = 32'd0;
    bus.EretM     = 1'b0;
  endtask

  task automatic drive_m(input logic [31:0] pc, input logic [4:0] code, input logic bd);
    bus.Valid_M   = 1'b1;
    bus.PC_M      = pc;
    bus.ExcCode_M = code;
    bus.BD_M      = bd;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    bus.WE  = 1'b1;
    bus.A2  = r;
    bus.DIn = d;
  endtask

  task automatic read_cp0(input logic [4:0] r, input string tag, input logic [31:0] exp);
    bus.A1 = r;
    #1;
    expect_v(tag, exp);
    observe(bus.DOut);
  endtask

  task automatic chk_redirect(input string tag, input logic [31:0] tgt);
    expect_v({tag, "_flush"}, 32'd1);
    expect_v({tag, "_redir"}, 32'd1);
    expect_v({tag, "_target"}, tgt);
    observe({31'd0, bus.Flush});
    observe({31'd0, bus.Redirect});
    observe(bus.Target);
  endtask

  task automatic chk_noflush(input string tag);
    expect_v(tag, 32'd0);
    observe({31'd0, bus.Flush});
  endtask

  task automatic chk_exl(input string tag, input logic e);
    expect_v({tag, "_exl"}, {31'd0, e});
    expect_v({tag, "_state"}, {31'd0, e});
    observe({31'd0, bus.EXL});
    observe({31'd0, bus.state_dbg});
  endtask

  initial begin
    logic [5:0] hw;
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.HWInt = 6'd0;
    bus.A1    = 5'd0;
    idle();
    repeat (2) step();
    reset = 1'b0;
    settle();

    // Reset state
    expect_v("rst_flush", 32'd0);
    expect_v("rst_redir", 32'd0);
    expect_v("rst_target", 32'd0);
    observe({31'd0, bus.Flush});
    observe({31'd0, bus.Redirect});
    observe(bus.Target);
    chk_exl("rst", 1'b0);
    read_cp0(CP0_SR, "rst_sr", 32'd0);
    read_cp0(CP0_PRID, "rst_prid", PRID);

    // RI trap
    drive_m(32'h3010, EXC_RI, 1'b0);
    settle();
    chk_redirect("t1_trap", HANDLER);
    step(); idle(); settle();
    chk_exl("t1_after", 1'b1);
    expect_v("t1_epc_out", 32'h3010);
    observe(bus.EPC_out);
    read_cp0(CP0_CAUSE, "t1_cause", 32'h0000_0028);
    read_cp0(CP0_EPC, "t1_epc", 32'h3010);
    bus.EretM = 1'b1;
    settle();
    chk_redirect("t1_eret", 32'h3010);
    step(); idle(); settle();
    chk_exl("t1_ret", 1'b0);

    // Delay-slot interrupt
    mtc0(CP0_SR, 32'h0000_0401);
    bus.Valid_M = 1'b1;
    settle();
    chk_noflush("t2_mtc0_noflush");
    step(); idle();
    read_cp0(CP0_SR, "t2_sr", 32'h0000_0401);
    bus.HWInt = 6'b000001;
    drive_m(32'h3024, EXC_ADEL, 1'b1);
    settle();
    chk_redirect("t2_trap", HANDLER);
    step(); idle(); settle();
    chk_exl("t2_after", 1'b1);
    read_cp0(CP0_CAUSE, "t2_cause", 32'h8000_0400);
    expect_v("t2_epc_out", 32'h3020);
    observe(bus.EPC_out);
    bus.HWInt = 6'd0;
    bus.EretM = 1'b1;
    settle();
    chk_redirect("t2_eret", 32'h3020);
    step(); idle(); settle();
    chk_exl("t2_ret", 1'b0);

    // Bubble deferral
    bus.HWInt = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_noflush($sformatf("t3_bubble%0d", i));
      step();
    end
    drive_m(32'h3040, 5'd0, 1'b0);
    settle();
    chk_redirect("t3_trap", HANDLER);
    step();
    drive_m(32'h3044, 5'd0, 1'b0);
    settle();
    chk_noflush("t3_no_dup");
    expect_v("t3_epc_out", 32'h3040);
    observe(bus.EPC_out);
    read_cp0(CP0_CAUSE, "t3_cause", 32'h0000_0400);

    // Masking in handler, then return
    drive_m(32'h3048, EXC_OV, 1'b0);
    settle();
    chk_noflush("t4_masked");
    step(); idle();
    bus.HWInt = 6'd0;
    bus.EretM = 1'b1;
    settle();
    chk_redirect("t4_eret", 32'h3040);
    step(); idle(); settle();
    chk_exl("t4_ret", 1'b0);

    // EPC bypass into eret
    drive_m(32'h3050, EXC_RI, 1'b0);
    settle();
    step(); idle(); settle();
    chk_exl("t5_in", 1'b1);
    mtc0(CP0_EPC, 32'h3100);
    bus.EretM = 1'b1;
    settle();
    chk_redirect("t5_bypass", 32'h3100);
    step(); idle();
    read_cp0(CP0_EPC, "t5_epc", 32'h3100);
    chk_exl("t5_ret", 1'b0);

    // mtc0 SR colliding with a trap
    mtc0(CP0_SR, 32'h0000_FC00);
    drive_m(32'h3060, EXC_OV, 1'b0);
    settle();
    chk_redirect("t5_coll", HANDLER);
    step(); idle();
    read_cp0(CP0_SR, "t5_coll_sr", 32'h0000_0403);
    chk_exl("t5_coll", 1'b1);

    // mtc0 to SR.EXL drives the FSM both ways
    mtc0(CP0_SR, 32'h0000_0401);
    step(); idle(); settle();
    chk_exl("t5_mtc0_run", 1'b0);
    mtc0(CP0_SR, 32'h0000_0403);
    step(); idle(); settle();
    chk_exl("t5_mtc0_hdl", 1'b1);
    drive_m(32'h3068, EXC_ADES, 1'b0);
    settle();
    chk_noflush("t5_mtc0_masked");
    step(); idle();
    mtc0(CP0_SR, 32'h0000_0401);
    step(); idle();
    drive_m(32'h3070, EXC_ADES, 1'b0);
    settle();
    chk_redirect("t5_ades", HANDLER);
    step(); idle();
    read_cp0(CP0_CAUSE, "t5_ades_cause", 32'h0000_0014);

    // Reads: PrID and live IP
    read_cp0(CP0_PRID, "t6_prid", PRID);
    read_cp0(5'd3, "t6_other", 32'd0);
    for (int i = 0; i < 4; i++) begin
      hw = 6'($urandom_range(0, 63));
      bus.HWInt = hw;
      step();
      read_cp0(CP0_CAUSE, $sformatf("t6_ip%0d", i), ({26'd0, hw} << 10) | 32'h14);
    end

    // Reset mid-handler overrides eret/mtc0/trap
    reset = 1'b1;
    bus.EretM = 1'b1;
    mtc0(CP0_EPC, 32'hDEAD_BEEC);
    drive_m(32'h3080, EXC_RI, 1'b0);
    bus.HWInt = 6'h3f;
    settle();
    chk_noflush("t6_rst_noflush");
    step(); idle(); settle();
    chk_exl("t6_rst", 1'b0);
    read_cp0(CP0_SR, "t6_rst_sr", 32'd0);
    read_cp0(CP0_CAUSE, "t6_rst_cause", 32'd0);
    read_cp0(CP0_EPC, "t6_rst_epc", 32'd0);
    expect_v("t6_rst_epc_out", 32'd0);
    observe(bus.EPC_out);
    reset = 1'b0;
    bus.HWInt = 6'd0;
    step();

    check_val("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 and exception/interrupt controller for the 5-stage MIPS pipeline.
- Takes the pipelined exception code, BD flag and PC of the instruction in M, plus six hardware interrupt lines.
- Decides when the pipeline traps or returns: raises flush, redirects fetch to the handler or to EPC, and maintains SR/Cause/EPC/PrID for mfc0/mtc0/eret.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, fetch redirect target on any trap.
- PRID_VAL, 32'h2018_1225, read-only value of PrID (reg 15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- PC_M  in  32  PC of the instruction in M.
- Valid_M  in  1  M holds a real instruction (0 = bubble).
- ExcCode_M  in  5 [6:2]  pipelined exception code; 0 = none.
- BD_M  in  1  M instruction sits in a branch delay slot.
- HWInt  in  6 [7:2]  level-sensitive hardware interrupt lines.
- WE  in  1  mtc0 in M.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- EretM  in  1  eret in M.
- DOut  out  32  mfc0 read data (combinational).
- EPC_out  out  32  eret return target.
- Flush  out  1  kill F/D/E/M this cycle (combinational).
- Redirect  out  1  load NPC from Target this cycle.
- Target  out  32  HANDLER_ADDR on trap, EPC_out on eret.
- EXL  out  1  current SR.EXL.

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits 0.
  - EPC(14): 32 bits.
  - PrID(15): constant PRID_VAL.
  - Reading any other register number returns 0.
- Reset: SR=0, Cause=0, EPC=0, FSM=RUN. After reset: Flush=0, Redirect=0, Target=0, DOut per A1, EXL=0.
- FSM state RUN (EXL=0):
  - IntReq = |(HWInt & SR.IM) & SR.IE & Valid_M.
  - ExcReq = (ExcCode_M!=0) & Valid_M.
  - Req = IntReq | ExcReq, combinational same cycle. Req asserts Flush=1, Redirect=1, Target=HANDLER_ADDR.
  - At the clock edge on Req: EXL<=1; Cause.BD<=BD_M; EPC<={BD_M ? PC_M-4 : PC_M}[31:2],2'b00; Cause.ExcCode<=IntReq ? 0 : ExcCode_M. Interrupt has priority over a synchronous exception. FSM -> HANDLER.
- FSM state HANDLER (EXL=1):
  - IntReq and ExcReq are masked to 0.
  - EretM=1: Flush=1, Redirect=1, Target=EPC_out. At the edge EXL<=0 and FSM -> RUN.
- Pending interrupt while Valid_M=0: no trap. It waits for the first valid M instruction, with no loss and no duplicate trap.
- Cause.IP <= HWInt every cycle, in both states, including the trap cycle.
- mtc0: at the edge, writes SR (IM/EXL/IE fields only) or EPC when WE=1. Writes to Cause/PrID are ignored.
  - Same cycle as Req: Req wins and the write is dropped.
  - mtc0 writing SR.EXL also moves the FSM (EXL=1 -> HANDLER, 0 -> RUN). FSM always equals EXL.
- EPC_out = (WE && A2==14) ? DIn : EPC. This bypass covers an mtc0-EPC immediately followed by eret.
- EretM and Req cannot coexist: EretM is only honoured in HANDLER.
- Reset mid-handler returns to RUN with all registers cleared; it overrides any concurrent Req, EretM or WE.

Decomposition:
- Shared include (define.v): CP0 register numbers 12/13/14/15, SR/Cause field bit positions, ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), HANDLER_ADDR default.
- One natural sub-module, cp0_regfile: SR/Cause/EPC/PrID storage plus the read mux. The trap/eret decision FSM stays in cp0_exc_ctrl.

Test Plan:
1. RI trap: RUN, Valid_M=1, PC_M=0x3010, ExcCode_M=10, BD_M=0 -> same cycle Flush=1, Redirect=1, Target=0x4180. Next cycle EPC=0x3010, Cause[6:2]=10, EXL=1.
2. Delay-slot interrupt: mtc0 SR=0x0000_0401 (IM[10], IE). Then HWInt=6'b000001, PC_M=0x3024, BD_M=1, ExcCode_M=4 -> trap. Cause.ExcCode=0 (interrupt wins), Cause.BD=1, EPC=0x3020.
3. Bubble deferral: interrupt enabled, HWInt asserted, Valid_M=0 for 3 cycles -> Flush stays 0. On Valid_M=1 with PC_M=0x3040 -> exactly one trap, EPC=0x3040.
4. Masking and return: in HANDLER, raise ExcCode_M=12 -> no Flush. Then EretM=1 -> Target=EPC, Flush=1, next cycle EXL=0.
5. Bypass and collision: WE=1, A2=14, DIn=0x3100 together with EretM=1 -> Target=0x3100. Separately, WE=1 to SR in the same cycle as a Req -> SR.IM unchanged, EXL=1.
6. Reads and reset: A1=15 -> DOut=PRID_VAL; A1=13 shows IP following HWInt live. reset=1 in HANDLER -> next cycle SR=Cause=EPC=0, EXL=0.
